// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only sequencer: runs the power-on nibble init, then
// splits accepted command/data bytes into two timed E strobes plus an execution wait.
module lcd_hd44780_ctrl #(
    parameter int T_SETUP = 4,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 1000,
    parameter int T_LONG  = 45000,
    parameter int T_PWRUP = 1100000,
    parameter int T_INIT1 = 111000,
    parameter int T_INIT2 = 2700
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    input  logic       req_long,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_db
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(max_of(T_SETUP, T_EPW), max_of(T_HOLD, T_CMD)),
                                  max_of(max_of(T_LONG, T_PWRUP), max_of(T_INIT1, T_INIT2)));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    // The counter is loaded with N-1 on entry so a state lasts exactly N cycles.
    function automatic logic [CNT_W-1:0] ld_val(input int t);
        return CNT_W'(t - 1);
    endfunction

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic             lat_rs_q, lat_rs_d;
    logic [7:0]       lat_data_q, lat_data_d;
    logic             lat_long_q, lat_long_d;
    logic             lcd_e_q, lcd_e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       lcd_db_q, lcd_db_d;
    logic             req_ready_q, req_ready_d;
    logic             init_done_q, init_done_d;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= ld_val(T_PWRUP);
            step_q      <= '0;
            lat_rs_q    <= 1'b0;
            lat_data_q  <= '0;
            lat_long_q  <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_db_q    <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lat_rs_q    <= lat_rs_d;
            lat_data_q  <= lat_data_d;
            lat_long_q  <= lat_long_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_db_q    <= lcd_db_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
        end
    end

    // step_q counts init nibbles 0..3 before init_done, and high/low nibble after.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        step_d     = step_q;
        lat_rs_d   = lat_rs_q;
        lat_data_d = lat_data_q;
        lat_long_d = lat_long_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_db_d   = lcd_db_q;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETUP;
                    cnt_d   = ld_val(T_SETUP);
                    step_d  = 2'd0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EHIGH;
                    cnt_d   = ld_val(T_EPW);
                end
            end
            ST_EHIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = ld_val(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (init_done_q) begin
                        if (step_q == 2'd0) begin
                            state_d = ST_SETUP;
                            cnt_d   = ld_val(T_SETUP);
                            step_d  = 2'd1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = lat_long_q ? ld_val(T_LONG) : ld_val(T_CMD);
                        end
                    end else begin
                        state_d = ST_WAIT;
                        case (step_q)
                            2'd0:    cnt_d = ld_val(T_INIT1);
                            2'd1:    cnt_d = ld_val(T_INIT2);
                            default: cnt_d = ld_val(T_CMD);
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (init_done_q || step_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = ld_val(T_SETUP);
                        step_d  = step_q + 2'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_SETUP;
                    cnt_d      = ld_val(T_SETUP);
                    step_d     = 2'd0;
                    lat_rs_d   = req_rs;
                    lat_data_d = req_data;
                    lat_long_d = req_long;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = ld_val(T_PWRUP);
            end
        endcase

        // RS/DB only change on SETUP entry; they hold through WAIT and IDLE.
        if (state_d == ST_SETUP && state_q != ST_SETUP) begin
            if (!init_done_q) begin
                lcd_rs_d = 1'b0;
                lcd_db_d = (step_d == 2'd3) ? 4'h2 : 4'h3;
            end else begin
                lcd_rs_d = lat_rs_d;
                lcd_db_d = (step_d == 2'd0) ? lat_data_d[7:4] : lat_data_d[3:0];
            end
        end

        lcd_e_d     = (state_d == ST_EHIGH);
        req_ready_d = (state_d == ST_IDLE);
        init_done_d = init_done_q | (state_d == ST_IDLE);
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rw    = 1'b0;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing; a negedge monitor
// records E pulses and flags RS/DB movement near or during E.
module tb_lcd_hd44780_ctrl;

    localparam int T_SETUP = 2;
    localparam int T_EPW   = 3;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 10;
    localparam int T_LONG  = 50;
    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 15;
    localparam int T_INIT2 = 5;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_long;
    logic       init_done;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [3:0] lcd_db;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int tviol  = 0;

    logic [3:0] p_db[$];
    logic       p_rs[$];
    logic       p_rw[$];
    int         p_rise[$];
    int         p_w[$];

    lcd_hd44780_ctrl #(
        .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD), .T_CMD(T_CMD),
        .T_LONG(T_LONG), .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_long  (req_long),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rw    (lcd_rw),
        .lcd_rs    (lcd_rs),
        .lcd_db    (lcd_db)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse recorder and setup/hold watchdog, sampled away from the active edge.
    logic       e_p1 = 1'b0, e_p2 = 1'b0;
    logic [4:0] d_p1 = '0, d_p2 = '0;
    int         width = 0;

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            if (e_p1) p_w.push_back(width);
            e_p1  = 1'b0;
            e_p2  = 1'b0;
            d_p1  = '0;
            d_p2  = '0;
            width = 0;
        end else begin
            if (lcd_e && !e_p1) begin
                p_db.push_back(lcd_db);
                p_rs.push_back(lcd_rs);
                p_rw.push_back(lcd_rw);
                p_rise.push_back(cyc);
                width = 0;
                if (d_p2 !== {lcd_rs, lcd_db}) tviol++;
            end
            if (lcd_e) begin
                width++;
                if (width > T_EPW) tviol++;
            end
            if (!lcd_e && e_p1) p_w.push_back(width);
            if ((lcd_e || e_p1 || e_p2) && ({lcd_rs, lcd_db} !== d_p1)) tviol++;
            e_p2 = e_p1;
            e_p1 = lcd_e;
            d_p2 = d_p1;
            d_p1 = {lcd_rs, lcd_db};
        end
    end

    task automatic applyStimulus(input logic valid, input logic rs, input logic [7:0] data,
                                 input logic long_wait);
        req_valid = valid;
        req_rs    = rs;
        req_data  = data;
        req_long  = long_wait;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitInit(input int base, input logic scramble, output int rel);
        rel = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (init_done) begin
                rel = cyc - base;
                break;
            end
            if (scramble) req_data = req_data + 8'h11;
        end
    endtask

    task automatic waitReady(input int base, output int rel);
        rel = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (req_ready) begin
                rel = cyc - base;
                break;
            end
        end
    endtask

    task automatic checkPulses(input string tag, input int start, input int n,
                               input logic [15:0] exp_db, input logic exp_rs);
        int idx;
        checkOutput({tag, "_count"}, 32'(p_db.size() - start), 32'(n));
        for (int i = 0; i < n; i++) begin
            idx = start + i;
            checkOutput({tag, "_db"}, (idx < p_db.size()) ? 32'(p_db[idx]) : 'x,
                        32'(4'(exp_db >> (4 * (n - 1 - i)))));
            checkOutput({tag, "_rs"}, (idx < p_rs.size()) ? 32'(p_rs[idx]) : 'x, 32'(exp_rs));
            checkOutput({tag, "_rw"}, (idx < p_rw.size()) ? 32'(p_rw[idx]) : 'x, 32'd0);
            checkOutput({tag, "_width"}, (idx < p_w.size()) ? 32'(p_w[idx]) : 'x, 32'(T_EPW));
        end
    endtask

    int base, k, rel, pidx;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_outputs", {lcd_e, lcd_rw, lcd_rs, lcd_db, req_ready, init_done}, '0);

        // Init with req_valid held high and garbage data churning.
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1);
        #1 rst_n = 1'b1;
        base = cyc;
        pidx = p_db.size();
        waitInit(base, 1'b1, rel);
        checkOutput("init_done_edge", rel, 88);
        checkOutput("init_ready", req_ready, 1'b1);
        checkPulses("init", pidx, 4, 16'h3332, 1'b0);
        checkOutput("init_first_rise", (pidx < p_rise.size()) ? 32'(p_rise[pidx] - base) : 'x, 22);

        // Data byte presented on the IDLE-entry sample, accepted on the next edge.
        pidx = p_db.size();
        applyStimulus(1'b1, 1'b1, 8'h41, 1'b0);
        @(negedge sys_clk);
        k = cyc;
        checkOutput("data_accept_edge", k - base, 89);
        checkOutput("data_ready_drop", req_ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1);
        waitReady(k, rel);
        checkOutput("data_latency", rel, 24);
        checkPulses("data", pidx, 2, 16'h0041, 1'b1);

        // Clear display with long wait.
        pidx = p_db.size();
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b1);
        @(negedge sys_clk);
        k = cyc;
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
        waitReady(k, rel);
        checkOutput("clear_latency", rel, 64);
        checkPulses("clear", pidx, 2, 16'h0001, 1'b0);

        // Back-to-back: valid held through the busy byte while data changes.
        pidx = p_db.size();
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
        @(negedge sys_clk);
        k = cyc;
        checkOutput("b2b_first_drop", req_ready, 1'b0);
        rel = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (req_ready) begin
                rel = cyc - k;
                break;
            end
            req_data = req_data ^ 8'h3C;
        end
        checkOutput("b2b_first_latency", rel, 24);
        req_data = 8'hC3;
        @(negedge sys_clk);
        checkOutput("b2b_one_idle", req_ready, 1'b0);
        checkOutput("b2b_second_accept", cyc - k, 25);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        waitReady(k, rel);
        checkOutput("b2b_second_latency", rel, 49);
        checkPulses("b2b", pidx, 4, 16'h5AC3, 1'b1);

        // Reset during EHIGH of the low nibble.
        applyStimulus(1'b1, 1'b1, 8'h7E, 1'b0);
        @(negedge sys_clk);
        k = cyc;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (10) @(negedge sys_clk);
        checkOutput("midbyte_e_high", lcd_e, 1'b1);
        checkOutput("midbyte_low_nibble", lcd_db, 4'hE);
        #2 rst_n = 1'b0;
        #1 checkOutput("midbyte_reset_outputs",
                       {lcd_e, lcd_rw, lcd_rs, lcd_db, req_ready, init_done}, '0);
        repeat (2) @(negedge sys_clk);
        #1 rst_n = 1'b1;
        base = cyc;
        pidx = p_db.size();
        waitInit(base, 1'b0, rel);
        checkOutput("reinit_done_edge", rel, 88);
        checkPulses("reinit", pidx, 4, 16'h3332, 1'b0);

        repeat (5) @(negedge sys_clk);
        checkOutput("timing_monitor", tviol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Hardware sequencer for the character LCD (HD44780-compatible, 4-bit bus, write-only).
- Replaces CPU bit-banging of E/RS/DB through the IO-mapped LCD register.
- Accepts whole command/data bytes over a valid/ready handshake and splits each byte into two nibble strobes with programmable setup, pulse and hold timing plus a post-byte execution delay.
- Runs the power-on 4-bit initialisation nibble sequence autonomously after reset.

Parameters:
- T_SETUP, 4: cycles RS/DB are stable before E rises (≥1).
- T_EPW, 12: cycles E is held high (≥1).
- T_HOLD, 4: cycles RS/DB are held after E falls (≥1).
- T_CMD, 1000: post-byte wait for a normal command or data byte (≥1).
- T_LONG, 45000: post-byte wait when req_long is set (clear/home) (≥1).
- T_PWRUP, 1100000: wait after reset before the first init nibble (≥1).
- T_INIT1, 111000: wait after init nibble 1 (≥1).
- T_INIT2, 2700: wait after init nibble 2 (≥1).

Ports:
- sys_clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: byte request.
- req_ready, output, 1: controller can accept a byte.
- req_rs, input, 1: 0 = command, 1 = data.
- req_data, input, 8: byte to write.
- req_long, input, 1: use T_LONG instead of T_CMD.
- init_done, output, 1: init sequence complete (sticky until reset).
- lcd_e, output, 1: LCD enable strobe.
- lcd_rw, output, 1: constant 0.
- lcd_rs, output, 1: register select.
- lcd_db, output, 4: LCD DB[7:4].

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock sys_clk.
- Reset values: lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db=0, req_ready=0, init_done=0. The FSM enters PWRUP.
- Reset mid-operation: abort immediately to the reset values. Init restarts from PWRUP.
- States: PWRUP, SETUP, EHIGH, HOLD, WAIT, IDLE.
- Single down-counter, width = $clog2 of the largest parameter + 1. Each state lasts exactly its parameter in cycles.
- Nibble strobe (SETUP → EHIGH → HOLD):
  - SETUP: E=0, RS/DB driven.
  - EHIGH: E=1.
  - HOLD: E=0, RS/DB held.
  - Length = S+E+H = T_SETUP+T_EPW+T_HOLD cycles.
- Init sequence: PWRUP (T_PWRUP), then four nibbles 3,3,3,2 with RS=0. Waits after each nibble are T_INIT1, T_INIT2, T_CMD, T_CMD. Then IDLE.
- init_done and req_ready assert on the same edge IDLE is entered.
- Handshake:
  - req_ready=1 only in IDLE.
  - Transfer occurs when req_valid && req_ready on a rising edge. req_rs, req_data and req_long are latched on that edge. req_ready drops the next cycle.
  - req_valid while req_ready=0 is ignored and nothing is latched. The requester must hold its request.
- Byte sequence: high nibble req_data[7:4] strobe, then low nibble [3:0] strobe, with RS=latched req_rs for both. Then WAIT for T_LONG if the latched req_long=1, else T_CMD. Then IDLE.
- Latency: if the transfer edge is k, req_ready reasserts at edge k + 2·(S+E+H) + W, where W = T_CMD or T_LONG.
- Back-to-back: a request valid on the edge IDLE is entered is accepted on the following edge. IDLE lasts a minimum of 1 cycle.
- lcd_rs/lcd_db hold their last driven values through WAIT and IDLE until the next SETUP.
- lcd_e never exceeds one contiguous T_EPW-cycle pulse per nibble.
- No glitches: all outputs are registered.

Test Plan:
All scenarios use T_SETUP=2, T_EPW=3, T_HOLD=2, T_CMD=10, T_LONG=50, T_PWRUP=20, T_INIT1=15, T_INIT2=5. S+E+H=7.
- Init:
  - Stimulus: release reset.
  - Required: exactly 4 E pulses, each 3 cycles wide, with lcd_db = 3,3,3,2 and rs=0.
  - Required: no E activity during the first 20 cycles.
  - Required: init_done and req_ready rise at edge 88 after reset release.
- Data byte:
  - Stimulus: after init, send rs=1, data=0x41, long=0.
  - Required: pulses with db=4 then db=1, rs=1 throughout, rw=0.
  - Required: req_ready returns 24 cycles after the accept edge.
- Clear command:
  - Stimulus: send rs=0, data=0x01, long=1.
  - Required: db=0 then db=1, rs=0.
  - Required: req_ready returns 64 cycles after the accept edge.
- Handshake:
  - Stimulus: hold req_valid high during init and during a busy byte while changing req_data.
  - Required: nothing is latched while req_ready=0.
  - Required: the value present on the accept edge is transmitted; each byte is transmitted exactly once; back-to-back bytes are separated by exactly one IDLE cycle.
- Reset mid-byte:
  - Stimulus: assert rst_n low during EHIGH of the low nibble.
  - Required: lcd_e=0 and all outputs return to reset values immediately.
  - Required: the full init sequence replays and completes again at edge 88.
- Timing check:
  - Stimulus: run the above scenarios with an assertion monitor attached.
  - Required: DB/RS never change while E=1 or within 2 cycles before E rises or after E falls.
